// File: rtl/alu_wide_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_wide_sequencer_pkg
//   Shared constants for the single-width ALU and the wide sequencer that
//   drives it: slice width, operation encodings, processor flag positions,
//   sequencer state encodings and small operation-class helpers.
// ---------------------------------------------------------------------------
package alu_wide_sequencer_pkg;

    // Datapath width of one ALU slice and width of the operation code.
    localparam int ALU_INOUT_W  = 8;
    localparam int ALU_OPER_W   = 4;
    localparam int PROC_FLAGS_W = 4;

    // Positions of the processor flags inside a proc_flags vector.
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    // Packed view of a flag vector; bit order matches the FLAG_* positions.
    typedef struct packed {
        logic v;
        logic n;
        logic z;
        logic c;
    } proc_flags_t;

    // ALU operation encodings.
    localparam logic [ALU_OPER_W-1:0] OP_ADD  = 4'd0;
    localparam logic [ALU_OPER_W-1:0] OP_ADC  = 4'd1;
    localparam logic [ALU_OPER_W-1:0] OP_SUB  = 4'd2;
    localparam logic [ALU_OPER_W-1:0] OP_SBC  = 4'd3;
    localparam logic [ALU_OPER_W-1:0] OP_AND  = 4'd4;
    localparam logic [ALU_OPER_W-1:0] OP_ORR  = 4'd5;
    localparam logic [ALU_OPER_W-1:0] OP_XOR  = 4'd6;
    localparam logic [ALU_OPER_W-1:0] OP_CMP  = 4'd7;
    localparam logic [ALU_OPER_W-1:0] OP_LSL  = 4'd8;
    localparam logic [ALU_OPER_W-1:0] OP_LSR  = 4'd9;
    localparam logic [ALU_OPER_W-1:0] OP_ASR  = 4'd10;
    localparam logic [ALU_OPER_W-1:0] OP_ROL  = 4'd11;
    localparam logic [ALU_OPER_W-1:0] OP_ROR  = 4'd12;
    localparam logic [ALU_OPER_W-1:0] OP_ROLC = 4'd13;
    localparam logic [ALU_OPER_W-1:0] OP_RORC = 4'd14;

    // Sequencer FSM state encodings.
    localparam int SEQ_STATE_W = 2;
    localparam logic [SEQ_STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [SEQ_STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [SEQ_STATE_W-1:0] ST_DONE = 2'd2;

    // Operations the wide sequencer knows how to chain across slices.
    function automatic logic seq_oper_supported(input logic [ALU_OPER_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_ORR, OP_XOR,
            OP_LSL, OP_LSR, OP_ASR: seq_oper_supported = 1'b1;
            default:                seq_oper_supported = 1'b0;
        endcase
    endfunction

    // Right shifts must walk from the most significant slice downwards.
    function automatic logic seq_oper_ms_first(input logic [ALU_OPER_W-1:0] op);
        seq_oper_ms_first = (op == OP_LSR) || (op == OP_ASR);
    endfunction

    // Bitwise operations carry nothing between slices and report C=0.
    function automatic logic seq_oper_bitwise(input logic [ALU_OPER_W-1:0] op);
        seq_oper_bitwise = (op == OP_AND) || (op == OP_ORR) || (op == OP_XOR);
    endfunction

    // Operations whose overflow flag is meaningful.
    function automatic logic seq_oper_arith(input logic [ALU_OPER_W-1:0] op);
        seq_oper_arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/alu_wide_sequencer_alu.sv
// ---------------------------------------------------------------------------
// alu_wide_sequencer_alu
//   Single-width combinational ALU, one slice of the wide datapath.
//   Carry convention: for subtraction C=1 means "no borrow" (a >= b), so
//   sbc computes a + ~b + C and chains naturally from sub.
//   Shifts and rotates use i_b[log2(W)-1:0] as the shift count; C is the last
//   bit shifted out (0 for a zero count on lsl/lsr/asr). rolc/rorc rotate by
//   one through the incoming carry.
// Ports:
//   i_a, i_b   : slice operands
//   i_oper     : operation (OP_*)
//   i_flags    : incoming flags, only C is used
//   o_out      : slice result
//   o_flags    : C/Z/N/V of this slice
// ---------------------------------------------------------------------------
module alu_wide_sequencer_alu
    import alu_wide_sequencer_pkg::*;
(
    input  logic [ALU_INOUT_W-1:0]  i_a,
    input  logic [ALU_INOUT_W-1:0]  i_b,
    input  logic [ALU_OPER_W-1:0]   i_oper,
    input  logic [PROC_FLAGS_W-1:0] i_flags,
    output logic [ALU_INOUT_W-1:0]  o_out,
    output logic [PROC_FLAGS_W-1:0] o_flags
);

    localparam int W     = ALU_INOUT_W;
    localparam int SHC_W = $clog2(ALU_INOUT_W);

    logic             w_cin;
    logic [SHC_W-1:0] w_cnt;
    logic [W:0]       w_ext;
    logic [2*W-1:0]   w_rot;
    logic [W:0]       w_cin_ext;
    logic [W-1:0]     w_res;
    logic             w_c;
    logic             w_v;
    logic             w_unused_flags;

    assign w_cin          = i_flags[FLAG_C];
    assign w_cnt          = i_b[SHC_W-1:0];
    assign w_unused_flags = ^i_flags[PROC_FLAGS_W-1:1];

    always_comb begin
        w_ext     = '0;
        w_rot     = '0;
        w_cin_ext = '0;
        w_res     = '0;
        w_c       = 1'b0;
        w_v       = 1'b0;
        case (i_oper)
            OP_ADD, OP_ADC: begin
                w_cin_ext[0] = (i_oper == OP_ADC) ? w_cin : 1'b0;
                w_ext = {1'b0, i_a} + {1'b0, i_b} + w_cin_ext;
                w_res = w_ext[W-1:0];
                w_c   = w_ext[W];
                w_v   = (i_a[W-1] == i_b[W-1]) && (w_res[W-1] != i_a[W-1]);
            end
            OP_SUB, OP_CMP, OP_SBC: begin
                w_cin_ext[0] = (i_oper == OP_SBC) ? w_cin : 1'b1;
                w_ext = {1'b0, i_a} + {1'b0, ~i_b} + w_cin_ext;
                w_res = w_ext[W-1:0];
                w_c   = w_ext[W];
                w_v   = (i_a[W-1] != i_b[W-1]) && (w_res[W-1] != i_a[W-1]);
            end
            OP_AND: w_res = i_a & i_b;
            OP_ORR: w_res = i_a | i_b;
            OP_XOR: w_res = i_a ^ i_b;
            OP_LSL: begin
                // Bit W of the widened value is the last bit pushed out.
                w_ext = {1'b0, i_a} << w_cnt;
                w_res = w_ext[W-1:0];
                w_c   = w_ext[W];
            end
            OP_LSR: begin
                // A guard bit below the LSB catches the last bit shifted out.
                w_ext = {i_a, 1'b0} >> w_cnt;
                w_res = w_ext[W:1];
                w_c   = w_ext[0];
            end
            OP_ASR: begin
                w_ext = $signed({i_a, 1'b0}) >>> w_cnt;
                w_res = w_ext[W:1];
                w_c   = w_ext[0];
            end
            OP_ROL: begin
                w_rot = {i_a, i_a} << w_cnt;
                w_res = w_rot[2*W-1:W];
                w_c   = w_res[0];
            end
            OP_ROR: begin
                w_rot = {i_a, i_a} >> w_cnt;
                w_res = w_rot[W-1:0];
                w_c   = w_res[W-1];
            end
            OP_ROLC: begin
                w_res = {i_a[W-2:0], w_cin};
                w_c   = i_a[W-1];
            end
            OP_RORC: begin
                w_res = {w_cin, i_a[W-1:1]};
                w_c   = i_a[0];
            end
            default: begin
                w_res = '0;
            end
        endcase
    end

    assign o_out           = w_res;
    assign o_flags[FLAG_C] = w_c;
    assign o_flags[FLAG_Z] = (w_res == '0);
    assign o_flags[FLAG_N] = w_res[W-1];
    assign o_flags[FLAG_V] = w_v;

endmodule

// File: rtl/alu_wide_sequencer.sv
// ---------------------------------------------------------------------------
// alu_wide_sequencer
//   Runs wide (NUM_SLICES * SLICE_W) operations by stepping one shared
//   single-width ALU over the operand slices, one slice per cycle, chaining
//   the carry through a register.
//
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. req_ready is high only in IDLE; resp_valid is high only in
//   DONE and resp_out/resp_flags/resp_error are held until resp_ready.
//
// Ports:
//   master_clk, reset_n  : clock, async active-low reset
//   req_valid/req_ready  : request handshake
//   req_oper, req_a/b    : operation and wide operands (b ignored for shifts)
//   resp_valid/ready     : response handshake
//   resp_out             : wide result (0 for cmp and unsupported opers)
//   resp_flags           : wide C/Z/N/V
//   resp_error           : operation not supported by the sequencer
//   dbg_state            : current FSM state (ST_* encoding)
// ---------------------------------------------------------------------------
module alu_wide_sequencer
    import alu_wide_sequencer_pkg::*;
#(
    parameter int NUM_SLICES = 4
) (
    input  logic                              master_clk,
    input  logic                              reset_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ALU_OPER_W-1:0]             req_oper,
    input  logic [NUM_SLICES*ALU_INOUT_W-1:0] req_a,
    input  logic [NUM_SLICES*ALU_INOUT_W-1:0] req_b,
    output logic                              resp_valid,
    input  logic                              resp_ready,
    output logic [NUM_SLICES*ALU_INOUT_W-1:0] resp_out,
    output logic [PROC_FLAGS_W-1:0]           resp_flags,
    output logic                              resp_error,
    output logic [SEQ_STATE_W-1:0]            dbg_state
);

    localparam int SLICE_W = ALU_INOUT_W;
    localparam int WIDE_W  = NUM_SLICES * SLICE_W;
    localparam int CNT_W   = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SLICES - 1);

    logic [SEQ_STATE_W-1:0]  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_carry;
    logic [ALU_OPER_W-1:0]   r_oper;
    logic [WIDE_W-1:0]       r_a;
    logic [WIDE_W-1:0]       r_b;
    logic [WIDE_W-1:0]       r_res;
    logic                    r_zacc;
    logic                    r_n;
    logic                    r_v;
    logic [PROC_FLAGS_W-1:0] r_flags;
    logic                    r_error;

    logic [CNT_W-1:0]        w_idx;
    logic                    w_first;
    logic                    w_idx_ms;
    logic [SLICE_W-1:0]      w_a_slice;
    logic [SLICE_W-1:0]      w_b_slice;
    logic [ALU_OPER_W-1:0]   w_alu_oper;
    logic [SLICE_W-1:0]      w_alu_b;
    logic [PROC_FLAGS_W-1:0] w_alu_flags_in;
    logic [SLICE_W-1:0]      w_alu_out;
    logic [PROC_FLAGS_W-1:0] w_alu_flags;
    logic                    w_z_next;
    logic                    w_n_next;
    logic                    w_v_next;
    proc_flags_t             w_wide_flags;

    // Slice pointer: right shifts walk MS->LS so the bit leaving a higher
    // slice enters the next lower one through the carry.
    assign w_first   = (r_cnt == '0);
    assign w_idx     = seq_oper_ms_first(r_oper) ? (LAST - r_cnt) : r_cnt;
    assign w_idx_ms  = (w_idx == LAST);
    assign w_a_slice = r_a[w_idx*SLICE_W +: SLICE_W];
    assign w_b_slice = r_b[w_idx*SLICE_W +: SLICE_W];

    // The first slice runs the plain op; later slices run the carry-using
    // variant so the wide result matches a native wide operation.
    always_comb begin
        w_alu_oper = r_oper;
        w_alu_b    = w_b_slice;
        case (r_oper)
            OP_ADD:         w_alu_oper = w_first ? OP_ADD : OP_ADC;
            OP_SUB, OP_CMP: w_alu_oper = w_first ? OP_SUB : OP_SBC;
            OP_LSL: begin
                w_alu_oper = w_first ? OP_LSL : OP_ROLC;
                w_alu_b    = SLICE_W'(1);
            end
            OP_LSR: begin
                w_alu_oper = w_first ? OP_LSR : OP_RORC;
                w_alu_b    = SLICE_W'(1);
            end
            OP_ASR: begin
                w_alu_oper = w_first ? OP_ASR : OP_RORC;
                w_alu_b    = SLICE_W'(1);
            end
            default: w_alu_oper = r_oper;
        endcase
    end

    always_comb begin
        w_alu_flags_in         = '0;
        w_alu_flags_in[FLAG_C] = r_carry;
    end

    alu_wide_sequencer_alu seq_alu (
        .i_a     (w_a_slice),
        .i_b     (w_alu_b),
        .i_oper  (w_alu_oper),
        .i_flags (w_alu_flags_in),
        .o_out   (w_alu_out),
        .o_flags (w_alu_flags)
    );

    // Running wide flags including the slice being processed this cycle.
    // N and V belong to the MS slice, which is the first slice for right
    // shifts and the last slice otherwise, so they are latched when seen.
    assign w_z_next = r_zacc & w_alu_flags[FLAG_Z];
    assign w_n_next = w_idx_ms ? w_alu_flags[FLAG_N] : r_n;
    assign w_v_next = w_idx_ms ? w_alu_flags[FLAG_V] : r_v;

    always_comb begin
        w_wide_flags.c = seq_oper_bitwise(r_oper) ? 1'b0 : w_alu_flags[FLAG_C];
        w_wide_flags.z = w_z_next;
        w_wide_flags.n = w_n_next;
        w_wide_flags.v = seq_oper_arith(r_oper) ? w_v_next : 1'b0;
    end

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_oper  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_zacc  <= 1'b0;
            r_n     <= 1'b0;
            r_v     <= 1'b0;
            r_flags <= '0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_oper  <= req_oper;
                        r_a     <= req_a;
                        r_b     <= req_b;
                        r_cnt   <= '0;
                        r_carry <= 1'b0;
                        r_res   <= '0;
                        r_zacc  <= 1'b1;
                        r_n     <= 1'b0;
                        r_v     <= 1'b0;
                        r_flags <= '0;
                        if (seq_oper_supported(req_oper)) begin
                            r_error <= 1'b0;
                            r_state <= ST_RUN;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    r_carry <= w_alu_flags[FLAG_C];
                    r_zacc  <= w_z_next;
                    r_n     <= w_n_next;
                    r_v     <= w_v_next;
                    // cmp only produces flags; its result stays zero.
                    if (r_oper != OP_CMP) begin
                        r_res[w_idx*SLICE_W +: SLICE_W] <= w_alu_out;
                    end
                    if (r_cnt == LAST) begin
                        r_flags <= w_wide_flags;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        r_error <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Result and flags are only visible in DONE, so a partially built
    // result during RUN never reaches the outputs.
    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_DONE);
    assign resp_out   = resp_valid ? r_res : '0;
    assign resp_flags = resp_valid ? r_flags : '0;
    assign resp_error = r_error;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench for alu_wide_sequencer (NUM_SLICES=4, 8-bit slices).
// Flag vectors are written {V,N,Z,C}. Subtraction carry is "no borrow".
module tb_alu_wide_sequencer;
  import alu_wide_sequencer_pkg::*;

  logic        master_clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_oper;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_out;
  logic [3:0]  resp_flags;
  logic        resp_error;
  logic [1:0]  dbg_state;

  int checks;
  int errors;
  int cyc;

  alu_wide_sequencer #(.NUM_SLICES(4)) dut (
    .master_clk (master_clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_oper   (req_oper),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_out   (resp_out),
    .resp_flags (resp_flags),
    .resp_error (resp_error),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial master_clk = 1'b0;
  always #5 master_clk = ~master_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("assertion on %s", tag);
    end
  endtask

  // driver tasks
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge master_clk);
    req_valid = 1'b1;
    req_oper  = op;
    req_a     = a;
    req_b     = b;
    @(posedge master_clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until resp_valid is seen.
  task automatic wait_resp(output int n);
    n = 0;
    @(negedge master_clk);
    while (!resp_valid && n < 20) begin
      @(negedge master_clk);
      n++;
    end
  endtask

  task automatic take_resp;
    resp_ready = 1'b1;
    @(posedge master_clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic [31:0] exp_out, input logic [3:0] exp_flags);
    check({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, "_out"},   resp_out, exp_out);
    check({tag, "_flags"}, {28'b0, resp_flags}, {28'b0, exp_flags});
    check({tag, "_error"}, {31'b0, resp_error}, 32'd0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    req_valid  = 1'b0;
    req_oper   = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    reset_n    = 1'b0;
    repeat (3) @(negedge master_clk);

    // reset state
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_out", resp_out, 32'd0);
    check("rst_resp_flags", {28'b0, resp_flags}, 32'd0);
    check("rst_resp_error", {31'b0, resp_error}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    reset_n = 1'b1;

    // 1: add with carry ripple through three slices
    send(OP_ADD, 32'h00FF_FFFF, 32'h0000_0001);
    wait_resp(cyc);
    check("add1_latency", cyc, 32'd4);
    check_resp("add1", 32'h0100_0000, 4'b0000);
    take_resp();

    // 2: cmp of equal operands; every slice sub/sbc has no borrow so C=1
    send(OP_CMP, 32'h1234_5678, 32'h1234_5678);
    wait_resp(cyc);
    check_resp("cmp", 32'h0000_0000, 4'b0011);
    take_resp();

    // 3: right shifts (MS->LS), left shift (LS->MS)
    send(OP_LSR, 32'h8000_0001, 32'h0);
    wait_resp(cyc);
    check_resp("lsr", 32'h4000_0000, 4'b0001);
    take_resp();

    send(OP_ASR, 32'h8000_0000, 32'h0);
    wait_resp(cyc);
    check_resp("asr", 32'hC000_0000, 4'b0100);
    take_resp();

    send(OP_LSL, 32'h8000_0001, 32'h0);
    wait_resp(cyc);
    check_resp("lsl", 32'h0000_0002, 4'b0001);
    take_resp();

    // sub with borrow through all slices, signed overflow on add, and
    send(OP_SUB, 32'h0000_0000, 32'h0000_0001);
    wait_resp(cyc);
    check_resp("sub", 32'hFFFF_FFFF, 4'b0100);
    take_resp();

    send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_resp(cyc);
    check_resp("addv", 32'h8000_0000, 4'b1100);
    take_resp();

    send(OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F);
    wait_resp(cyc);
    check_resp("and", 32'h0F00_0F00, 4'b0000);
    take_resp();

    // 4: response held while resp_ready stays low
    send(OP_ADD, 32'h1234_5678, 32'h1111_1111);
    wait_resp(cyc);
    check("hold_latency", cyc, 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge master_clk);
      check("hold_out", resp_out, 32'h2345_6789);
      check("hold_flags", {28'b0, resp_flags}, 32'd0);
      check("hold_valid", {31'b0, resp_valid}, 32'd1);
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    take_resp();
    check("post_accept_req_ready", {31'b0, req_ready}, 32'd1);
    check("post_accept_valid", {31'b0, resp_valid}, 32'd0);

    send(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_resp(cyc);
    check("add2_latency", cyc, 32'd4);
    check_resp("add2", 32'h0000_0000, 4'b0011);
    take_resp();

    // 5: reset two RUN cycles into an add
    send(OP_ADD, 32'h0101_0101, 32'h0202_0202);
    @(posedge master_clk);
    @(posedge master_clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_valid", {31'b0, resp_valid}, 32'd0);
    check("abort_req_ready", {31'b0, req_ready}, 32'd1);
    check("abort_out", resp_out, 32'd0);
    check("abort_state", {30'b0, dbg_state}, 32'd0);
    @(negedge master_clk);
    reset_n = 1'b1;

    send(OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F);
    wait_resp(cyc);
    check("xor_latency", cyc, 32'd4);
    check_resp("xor", 32'hF0F0_0F0F, 4'b0100);
    take_resp();

    // 6: unsupported operation goes straight to DONE with an error
    send(OP_ROL, 32'hDEAD_BEEF, 32'h0000_0001);
    wait_resp(cyc);
    check("rol_latency", cyc, 32'd0);
    check("rol_valid", {31'b0, resp_valid}, 32'd1);
    check("rol_error", {31'b0, resp_error}, 32'd1);
    check("rol_out", resp_out, 32'd0);
    check("rol_flags", {28'b0, resp_flags}, 32'd0);
    take_resp();
    check("rol_after_req_ready", {31'b0, req_ready}, 32'd1);
    check("rol_after_error", {31'b0, resp_error}, 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
